// File: rtl/data_sram_resp_if.sv
// Request/response bundle between the EX-stage requester and the data SRAM responder.
interface data_sram_resp_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, stallreq
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, stallreq
    );
endinterface

// File: rtl/data_sram_resp.sv
// Single-port byte-writable data SRAM with registered read data.
// Optional wait-state FSM compiled in by defining DSRAM_WAIT_EN.
module data_sram_resp #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic             clk,
    input logic             resetn,
    data_sram_resp_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0]       mem [DEPTH];
    logic [31:0]       rdata_q;
    logic              stall_c;
    logic              acc_go;
    logic [3:0]        acc_wen;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       acc_wdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{bus.data_sram_addr[1:0], bus.data_sram_addr[31:ADDR_W+2]};

`ifdef DSRAM_WAIT_EN
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              lat_en;
    logic [3:0]        lat_wen;
    logic [ADDR_W-1:0] lat_idx;
    logic [31:0]       lat_wdata;

    // The completing access comes straight from the inputs in IDLE, from the latch in BUSY.
    always_comb begin
        stall_c   = 1'b0;
        acc_go    = 1'b0;
        acc_wen   = bus.data_sram_wen;
        acc_idx   = bus.data_sram_addr[ADDR_W+1:2];
        acc_wdata = bus.data_sram_wdata;
        case (state)
            IDLE: begin
                if (WAIT_CYCLES == 0) begin
                    acc_go = bus.data_sram_en;
                end else if (bus.data_sram_en) begin
                    stall_c = 1'b1;
                    acc_go  = (WAIT_CYCLES == 1);
                end
            end
            BUSY: begin
                stall_c   = 1'b1;
                acc_go    = lat_en && (cnt == 4'd1);
                acc_wen   = lat_wen;
                acc_idx   = lat_idx;
                acc_wdata = lat_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_en    <= 1'b0;
            lat_wen   <= '0;
            lat_idx   <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.data_sram_en && WAIT_CYCLES != 0) begin
                        lat_en    <= 1'b1;
                        lat_wen   <= bus.data_sram_wen;
                        lat_idx   <= bus.data_sram_addr[ADDR_W+1:2];
                        lat_wdata <= bus.data_sram_wdata;
                        cnt       <= CNT_INIT;
                        state     <= (WAIT_CYCLES > 1) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= DONE;
                    end
                end
                default: begin
                    lat_en <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
`else
    always_comb begin
        stall_c   = 1'b0;
        acc_go    = bus.data_sram_en;
        acc_wen   = bus.data_sram_wen;
        acc_idx   = bus.data_sram_addr[ADDR_W+1:2];
        acc_wdata = bus.data_sram_wdata;
    end
`endif

    assign bus.stallreq        = stall_c && resetn;
    assign bus.data_sram_rdata = rdata_q;

    // Array is not reset; resetn gating keeps an access aborted by reset from committing.
    always_ff @(posedge clk) begin
        if (acc_go && resetn) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (acc_wen[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (acc_go && acc_wen == 4'b0000) begin
            rdata_q <= mem[acc_idx];
        end
    end
endmodule

// File: tb/tb_data_sram_resp.sv
// Directed self-checking bench for data_sram_resp (zero-wait and DSRAM_WAIT_EN builds).
module tb_data_sram_resp;
    localparam int unsigned W = 3;
`ifdef DSRAM_WAIT_EN
    localparam int EXP_STALL = W;
`else
    localparam int EXP_STALL = 0;
`endif

    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    int   stalls;

    data_sram_resp_if bus ();

    data_sram_resp #(.ADDR_W(10), .WAIT_CYCLES(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request, hold it until stallreq has been low for a cycle, then release.
    task automatic access(input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, output int nstall);
        logic s;
        int   n;
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
        nstall = 0;
        n = 0;
        forever begin
            #1;
            s = bus.stallreq;
            if (s) nstall++;
            @(posedge clk);
            #1;
            n++;
            if (!s) break;
            if (n > 40) begin
                check("access_timeout", 32'(n), 32'd0);
                break;
            end
        end
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'b0000;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.data_sram_en    = 1'b0;
        bus.data_sram_wen   = 4'b0000;
        bus.data_sram_addr  = '0;
        bus.data_sram_wdata = '0;
        #2;
        check("reset_rdata", bus.data_sram_rdata, 32'h0);
        check("reset_stall", {31'd0, bus.stallreq}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // byte-lane write merge
        access(4'hF, 32'h40, 32'h11223344, stalls);
        check("wr_stall", 32'(stalls), 32'(EXP_STALL));
        check("wr_keeps_rdata", bus.data_sram_rdata, 32'h0);
        access(4'b0010, 32'h40, 32'h0000AA00, stalls);
        access(4'h0, 32'h40, 32'h0, stalls);
        check("byte_merge", bus.data_sram_rdata, 32'h1122AA44);
        check("rd_stall", 32'(stalls), 32'(EXP_STALL));

        // streaming reads
        access(4'hF, 32'h0, 32'd1, stalls);
        access(4'hF, 32'h4, 32'd2, stalls);
        access(4'hF, 32'h8, 32'd3, stalls);
        access(4'h0, 32'h0, 32'h0, stalls);
        check("stream0", bus.data_sram_rdata, 32'd1);
        access(4'h0, 32'h4, 32'h0, stalls);
        check("stream1", bus.data_sram_rdata, 32'd2);
        access(4'h0, 32'h8, 32'h0, stalls);
        check("stream2", bus.data_sram_rdata, 32'd3);
        check("stream_stall", 32'(stalls), 32'(EXP_STALL));
        check("idle_stall", {31'd0, bus.stallreq}, 32'd0);

        // address wrap and ignored low bits
        access(4'hF, 32'h1000, 32'hDEADBEEF, stalls);
        access(4'h0, 32'h0, 32'h0, stalls);
        check("wrap", bus.data_sram_rdata, 32'hDEADBEEF);
        access(4'h0, 32'h0000_000B, 32'h0, stalls);
        check("low_bits_ignored", bus.data_sram_rdata, 32'd3);

        // write leaves rdata alone
        access(4'hF, 32'h10, 32'd5, stalls);
        access(4'h0, 32'h10, 32'h0, stalls);
        check("rd_5", bus.data_sram_rdata, 32'd5);
        access(4'hF, 32'h10, 32'd9, stalls);
        check("hold_after_wr", bus.data_sram_rdata, 32'd5);
        @(posedge clk);
        #1;
        check("hold_idle", bus.data_sram_rdata, 32'd5);
        access(4'h0, 32'h10, 32'h0, stalls);
        check("rd_9", bus.data_sram_rdata, 32'd9);

`ifdef DSRAM_WAIT_EN
        // explicit wait-state timeline, request held through DONE
        access(4'hF, 32'h20, 32'hA5A5A5A5, stalls);
        bus.data_sram_en   = 1'b1;
        bus.data_sram_wen  = 4'h0;
        bus.data_sram_addr = 32'h20;
        #1;
        check("w_stall_T", {31'd0, bus.stallreq}, 32'd1);
        @(posedge clk); #1;
        check("w_stall_T1", {31'd0, bus.stallreq}, 32'd1);
        check("w_rdata_T1", bus.data_sram_rdata, 32'd9);
        @(posedge clk); #1;
        check("w_stall_T2", {31'd0, bus.stallreq}, 32'd1);
        check("w_rdata_T2", bus.data_sram_rdata, 32'd9);
        @(posedge clk); #1;
        check("w_stall_T3", {31'd0, bus.stallreq}, 32'd0);
        check("w_rdata_T3", bus.data_sram_rdata, 32'hA5A5A5A5);
        @(posedge clk); #1;
        check("w_rdata_T4", bus.data_sram_rdata, 32'hA5A5A5A5);
        bus.data_sram_en = 1'b0;
        #1;
        check("w_stall_T4", {31'd0, bus.stallreq}, 32'd0);

        // reset in the middle of a waited write
        access(4'hF, 32'h80, 32'h12345678, stalls);
        bus.data_sram_en    = 1'b1;
        bus.data_sram_wen   = 4'hF;
        bus.data_sram_addr  = 32'h80;
        bus.data_sram_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("rst_pre_stall", {31'd0, bus.stallreq}, 32'd1);
        resetn = 1'b0;
        #1;
        check("rst_mid_stall", {31'd0, bus.stallreq}, 32'd0);
        check("rst_mid_rdata", bus.data_sram_rdata, 32'h0);
        bus.data_sram_en  = 1'b0;
        bus.data_sram_wen = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        access(4'h0, 32'h80, 32'h0, stalls);
        check("rst_no_commit", bus.data_sram_rdata, 32'h12345678);
`endif

        // reset clears rdata but not memory
        resetn = 1'b0;
        #1;
        check("rst2_rdata", bus.data_sram_rdata, 32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        access(4'h0, 32'h40, 32'h0, stalls);
        check("mem_survives_rst", bus.data_sram_rdata, 32'h1122AA44);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
